sram_arbiter: RTL and testbench

//   Two-port arbiter sharing one single-port sram (1-cycle registered read) between two requesters,
//   e.g. the input-stream loader and the noise-detection read engine. Per-cycle grant with

---
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port sram (1-cycle registered read) between two requesters.
// Per-cycle combinational grant, round-robin tie-break and a bounded burst while both request.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req*_i, we*_i, addr*_i, wdata*_i  requester access (held until granted)
//   gnt*_o                            combinational grant; access happens at posedge when req&&gnt
//   rvalid*_o, rdata*_o               read return, one cycle after a granted read
//   sram_addr_o, sram_din_o, sram_wr_o, sram_dout_i   sram interface
module sram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  output logic                  sram_wr_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;  // owner_d is also this cycle's grant
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;    // last served port: 0 = port0, 1 = port1
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Grant decision and next-state
  always_comb begin
    owner_d   = OWN_NONE;
    cnt_d     = '0;
    last_d    = last_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;

    unique case (owner_q)
      OWN_P0: begin
        if (req0_i && (!req1_i || cnt_q < CNT_W'(BURST_MAX))) owner_d = OWN_P0;
        else if (req1_i)                                      owner_d = OWN_P1;
      end
      OWN_P1: begin
        if (req1_i && (!req0_i || cnt_q < CNT_W'(BURST_MAX))) owner_d = OWN_P1;
        else if (req0_i)                                      owner_d = OWN_P0;
      end
      default: begin
        if (req0_i && req1_i) owner_d = last_q ? OWN_P0 : OWN_P1;
        else if (req0_i)      owner_d = OWN_P0;
        else if (req1_i)      owner_d = OWN_P1;
      end
    endcase

    if (rst_i) owner_d = OWN_NONE;

    // Burst count saturates; a change of owner restarts it, idle clears it
    if (owner_d == OWN_NONE)      cnt_d = '0;
    else if (owner_d == owner_q)  cnt_d = (cnt_q == CNT_W'(BURST_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    else                          cnt_d = CNT_W'(1);

    if (owner_d == OWN_P0) last_d = 1'b0;
    if (owner_d == OWN_P1) last_d = 1'b1;

    rvalid0_d = (owner_d == OWN_P0) && !we0_i;
    rvalid1_d = (owner_d == OWN_P1) && !we1_i;
  end

  // Outputs: grants, sram mux, read return
  always_comb begin
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    sram_addr_o = '0;
    sram_din_o  = '0;
    sram_wr_o   = 1'b0;
    unique case (owner_d)
      OWN_P0: begin
        gnt0_o      = 1'b1;
        sram_addr_o = addr0_i;
        sram_din_o  = wdata0_i;
        sram_wr_o   = we0_i;
      end
      OWN_P1: begin
        gnt1_o      = 1'b1;
        sram_addr_o = addr1_i;
        sram_din_o  = wdata1_i;
        sram_wr_o   = we1_i;
      end
      default: ;
    endcase
    // Reset kills a read return already in flight
    rvalid0_o = rvalid0_q && !rst_i;
    rvalid1_o = rvalid1_q && !rst_i;
    rdata0_o  = sram_dout_i;
    rdata1_o  = sram_dout_i;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic against a behavioural model
// (grant rules from request/streak/last-winner history, plus an array memory image).
module tb_sram_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned BM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, sram_wr;
  logic [DW-1:0] rdata0, rdata1, sram_din, sram_dout;
  logic [AW-1:0] sram_addr;

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(BM)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .sram_addr_o(sram_addr), .sram_din_o(sram_din), .sram_wr_o(sram_wr),
    .sram_dout_i(sram_dout)
  );

  always #5 clk = ~clk;

  // Single-port sram, registered read returning the pre-write contents
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_wr) sram_mem[sram_addr] <= sram_din;
    sram_dout <= sram_mem[sram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  int            prev_g = 0;   // 0 none, 1 port0, 2 port1 (previous cycle's grant)
  int            streak = 0;   // consecutive cycles prev_g has been granted
  int            last_w = 2;   // last port that won
  logic          pend0 = 1'b0, pend1 = 1'b0;
  logic [DW-1:0] pend_d0 = '0, pend_d1 = '0;

  // Drive one cycle of inputs, check all outputs mid-cycle, then advance the model
  task automatic step(input logic r,
                      input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    @(posedge clk); #1;
    rst = r; req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;

    if (r)                 g = 0;
    else if (q0 && !q1)    g = 1;
    else if (q1 && !q0)    g = 2;
    else if (!q0 && !q1)   g = 0;
    else if (prev_g != 0)  g = (streak < int'(BM)) ? prev_g : 3 - prev_g;
    else                   g = 3 - last_w;

    ea = (g == 1) ? a0 : (g == 2) ? a1 : '0;
    ed = (g == 1) ? d0 : (g == 2) ? d1 : '0;
    ew = (g == 1) ? w0 : (g == 2) ? w1 : 1'b0;

    @(negedge clk);
    check_eq("gnt0", 32'(gnt0), 32'(g == 1));
    check_eq("gnt1", 32'(gnt1), 32'(g == 2));
    check_eq("sram_wr", 32'(sram_wr), 32'(ew));
    check_eq("sram_addr", 32'(sram_addr), 32'(ea));
    check_eq("sram_din", 32'(sram_din), 32'(ed));
    check_eq("rvalid0", 32'(rvalid0), 32'(pend0 && !r));
    check_eq("rvalid1", 32'(rvalid1), 32'(pend1 && !r));
    if (pend0 && !r) check_eq("rdata0", 32'(rdata0), 32'(pend_d0));
    if (pend1 && !r) check_eq("rdata1", 32'(rdata1), 32'(pend_d1));

    if (r) begin
      prev_g = 0; streak = 0; last_w = 2; pend0 = 1'b0; pend1 = 1'b0;
    end else begin
      streak = (g != 0 && g == prev_g) ? streak + 1 : (g != 0 ? 1 : 0);
      prev_g = g;
      if (g != 0) last_w = g;
      pend0 = (g == 1) && !w0;
      pend1 = (g == 2) && !w1;
      pend_d0 = mem_m[a0];
      pend_d1 = mem_m[a1];
      if (g != 0 && ew) mem_m[ea] = ed;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = '0;
      mem_m[i]    = '0;
    end

    // Reset held with both requesting: no grants, then port0 wins first tie
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'd1, '0, 1'b1, 1'b0, 8'd2, '0);
      check_eq("rst_gnt0", 32'(gnt0), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 8'd1, '0, 1'b1, 1'b0, 8'd2, '0);
    check_eq("rel_gnt0", 32'(gnt0), 32'd1);
    check_eq("rel_gnt1", 32'(gnt1), 32'd0);
    idle();

    // Port0 alone writes 50..59 to addr 0..9 without a stall
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, AW'(i), DW'(50 + i), 1'b0, 1'b0, '0, '0);
      check_eq("burst_gnt0", 32'(gnt0), 32'd1);
    end

    // Port1 reads addr 3
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd3, '0);
    idle();
    check_eq("rd_rvalid1", 32'(rvalid1), 32'd1);
    check_eq("rd_rdata1", 32'(rdata1), 32'd53);
    check_eq("rd_rvalid0", 32'(rvalid0), 32'd0);

    // Both requesting continuously: bursts of BURST_MAX alternate
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 1), '0);
      check_eq("rr_gnt1", 32'(gnt1), 32'((i / 4) % 2));
    end
    idle();

    // Single-cycle ties: winners alternate (port0 won last, so port1 first)
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'd5, '0, 1'b1, 1'b0, 8'd6, '0);
      check_eq("tie_gnt1", 32'(gnt1), 32'(i % 2 == 0));
      idle();
    end

    // Reset right after a granted port0 read
    step(1'b0, 1'b1, 1'b0, 8'd4, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 8'd4, '0, 1'b1, 1'b0, 8'd7, '0);
    check_eq("rstmid_rvalid0", 32'(rvalid0), 32'd0);
    check_eq("rstmid_gnt", 32'({gnt0, gnt1}), 32'd0);
    idle();
    check_eq("post_rst_rvalid0", 32'(rvalid0), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'd4, '0, 1'b1, 1'b0, 8'd7, '0);
    check_eq("post_rst_tie", 32'(gnt0), 32'd1);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 15)), DW'($urandom),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 15)), DW'($urandom));
      check_eq("onehot", 32'(gnt0 && gnt1), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
